// File: rtl/hazard_controller_if.sv
// Decode-side bundle between the OTTER decoder and the hazard controller.
// The master side is the decoder/pipeline; the slave side is the controller.
interface hazard_controller_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [4:0]           ID_RS1;
    logic [4:0]           ID_RS2;
    logic [4:0]           ID_RD;
    logic                 ID_USES_RS1;
    logic                 ID_USES_RS2;
    logic                 ID_REGWRITE;
    logic                 ID_MEMREAD_2;
    logic                 BRANCH_TAKEN;
    logic                 PC_STALL;
    logic                 FETCH_STALL;
    logic                 DEC_BUBBLE;
    logic                 FLUSH_FETCH;
    logic [1:0]           OVERRIDE_A;
    logic [2:0]           OVERRIDE_B;
    logic [CNT_WIDTH-1:0] STALL_CNT;
    logic [CNT_WIDTH-1:0] FLUSH_CNT;

    modport master (
        output ID_RS1, ID_RS2, ID_RD, ID_USES_RS1, ID_USES_RS2,
               ID_REGWRITE, ID_MEMREAD_2, BRANCH_TAKEN,
        input  PC_STALL, FETCH_STALL, DEC_BUBBLE, FLUSH_FETCH,
               OVERRIDE_A, OVERRIDE_B, STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_RD, ID_USES_RS1, ID_USES_RS2,
               ID_REGWRITE, ID_MEMREAD_2, BRANCH_TAKEN,
        output PC_STALL, FETCH_STALL, DEC_BUBBLE, FLUSH_FETCH,
               OVERRIDE_A, OVERRIDE_B, STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/hazard_controller.sv
// OTTER decode-stage hazard controller: EX/MEM scoreboard, forwarding selects,
// load-use stalls and taken-branch flushes with saturating event counters.
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                REG_CLOCK,
    input  logic                REG_RESET,
    hazard_controller_if.slave  bus
);

    localparam int unsigned FCNT_W = 2;
    localparam logic [1:0]  SEL_NONE = 2'd0;
    localparam logic [1:0]  SEL_EX   = 2'd1;
    localparam logic [1:0]  SEL_MEM  = 2'd2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } sb_entry_t;

    state_t               state, state_nxt;
    logic [FCNT_W-1:0]    fcnt, fcnt_nxt;
    sb_entry_t            sb_ex, sb_mem;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic       load_use;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_stall, fetch_stall, dec_bubble, flush_fetch;
    logic [1:0] ovr_a, ovr_b;

    // Producer in the scoreboard writes the register this source actually reads.
    function automatic logic hit(input sb_entry_t e, input logic [4:0] rs,
                                 input logic uses);
        return e.valid && e.regwrite && (e.rd != 5'd0) && (e.rd == rs) && uses;
    endfunction

    always_comb begin
        hit_ex_a  = hit(sb_ex,  bus.ID_RS1, bus.ID_USES_RS1);
        hit_ex_b  = hit(sb_ex,  bus.ID_RS2, bus.ID_USES_RS2);
        hit_mem_a = hit(sb_mem, bus.ID_RS1, bus.ID_USES_RS1);
        hit_mem_b = hit(sb_mem, bus.ID_RS2, bus.ID_USES_RS2);
        fwd_a     = hit_ex_a ? SEL_EX : (hit_mem_a ? SEL_MEM : SEL_NONE);
        fwd_b     = hit_ex_b ? SEL_EX : (hit_mem_b ? SEL_MEM : SEL_NONE);
        load_use  = sb_ex.memread && (hit_ex_a || hit_ex_b);
    end

    always_ff @(posedge REG_CLOCK) begin
        if (REG_RESET) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // The branch cycle itself is the first flush cycle; FCNT holds the ones left.
    always_comb begin
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        pc_stall    = 1'b0;
        fetch_stall = 1'b0;
        dec_bubble  = 1'b0;
        flush_fetch = 1'b0;
        ovr_a       = SEL_NONE;
        ovr_b       = SEL_NONE;
        case (state)
            RUN, LOAD_STALL: begin
                if (bus.BRANCH_TAKEN) begin
                    flush_fetch = 1'b1;
                    dec_bubble  = 1'b1;
                    fcnt_nxt    = FCNT_W'(FLUSH_CYCLES - 1);
                    state_nxt   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if ((state == RUN) && load_use) begin
                    pc_stall    = 1'b1;
                    fetch_stall = 1'b1;
                    dec_bubble  = 1'b1;
                    state_nxt   = LOAD_STALL;
                end else begin
                    ovr_a     = fwd_a;
                    ovr_b     = fwd_b;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                flush_fetch = 1'b1;
                dec_bubble  = 1'b1;
                if (fcnt <= FCNT_W'(1)) begin
                    fcnt_nxt  = '0;
                    state_nxt = RUN;
                end else begin
                    fcnt_nxt = fcnt - FCNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                fcnt_nxt  = '0;
            end
        endcase
    end

    // EX/MEM scoreboard shifts every cycle; a bubble enters EX as invalid.
    always_ff @(posedge REG_CLOCK) begin
        if (REG_RESET) begin
            sb_ex  <= '0;
            sb_mem <= '0;
        end else begin
            sb_mem <= sb_ex;
            if (dec_bubble) begin
                sb_ex <= '0;
            end else begin
                sb_ex <= '{valid: 1'b1, rd: bus.ID_RD,
                           regwrite: bus.ID_REGWRITE, memread: bus.ID_MEMREAD_2};
            end
        end
    end

    always_ff @(posedge REG_CLOCK) begin
        if (REG_RESET) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (flush_fetch && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Everything reads zero while reset is held, whatever the state was.
    always_comb begin
        bus.PC_STALL    = pc_stall    & ~REG_RESET;
        bus.FETCH_STALL = fetch_stall & ~REG_RESET;
        bus.DEC_BUBBLE  = dec_bubble  & ~REG_RESET;
        bus.FLUSH_FETCH = flush_fetch & ~REG_RESET;
        bus.OVERRIDE_A  = REG_RESET ? 2'd0 : ovr_a;
        bus.OVERRIDE_B  = REG_RESET ? 3'd0 : {1'b0, ovr_b};
        bus.STALL_CNT   = REG_RESET ? '0 : stall_cnt;
        bus.FLUSH_CNT   = REG_RESET ? '0 : flush_cnt;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard controller for the OTTER 5-stage core.
- Tracks destination registers of the two in-flight instructions ahead of decode (EX, MEM) in an internal scoreboard.
- Drives the decode-stage forwarding override selects (OVERRIDE_A/OVERRIDE_B), load-use stalls and branch flushes.
- Sits beside the decode stage: stall/bubble outputs gate the PC, fetch register and decode register.

Parameters:
FLUSH_CYCLES, 2, number of cycles fetch/decode are squashed after a taken branch/jump (1..3)
CNT_WIDTH, 16, width of the saturating performance counters

Ports:
REG_CLOCK  in  1  core clock; all state updates on posedge
REG_RESET  in  1  synchronous, active-high reset
ID_RS1  in  5  rs1 field of the instruction in decode (FR_MEM[19:15])
ID_RS2  in  5  rs2 field of the instruction in decode (FR_MEM[24:20])
ID_RD  in  5  rd field of the instruction in decode (FR_MEM[11:7])
ID_USES_RS1  in  1  ALU source A selects rs1
ID_USES_RS2  in  1  ALU source B selects rs2
ID_REGWRITE  in  1  decoder REG_WRITE for the instruction in decode
ID_MEMREAD_2  in  1  decoder MEM_READ_2 (load) for the instruction in decode
BRANCH_TAKEN  in  1  execute stage resolved a taken branch/jump this cycle
PC_STALL  out  1  hold PC
FETCH_STALL  out  1  hold fetch register
DEC_BUBBLE  out  1  load all-zero control (NOP) into decode register
FLUSH_FETCH  out  1  zero the fetch register instruction
OVERRIDE_A  out  2  decode ALU_A override select: 0 = normal, 1 = Forward1 (EX result), 2 = Forward2 (MEM result)
OVERRIDE_B  out  3  decode ALU_B override select, same encoding; upper bit always 0
STALL_CNT  out  CNT_WIDTH  load-use stall cycles taken, saturating
FLUSH_CNT  out  CNT_WIDTH  flush cycles taken, saturating

Behaviour:
- Scoreboard: two registered entries, EX and MEM. Each entry holds {valid, rd, regwrite, memread}.
  - Each posedge: MEM <= EX.
  - EX <= DEC_BUBBLE ? invalid : {1, ID_RD, ID_REGWRITE, ID_MEMREAD_2}.
  - WB-stage writes are covered by register file write-before-read and are not tracked.
- Match condition: entry valid, regwrite = 1, rd != 0, rd == source reg, and the corresponding ID_USES_x = 1.
- Forward priority: EX match -> select 1; else MEM match -> select 2; else 0. Evaluated independently for A (rs1) and B (rs2).
- Load-use hazard: EX entry is a load (memread = 1) and matches either used source.
- FSM states RUN, LOAD_STALL, FLUSH; flush counter FCNT.
- RUN:
  - BRANCH_TAKEN = 1 -> FLUSH, FCNT <= FLUSH_CYCLES-1. Branch has priority over load-use.
  - Else load-use -> LOAD_STALL.
  - Else stay in RUN.
- Outputs are Mealy (combinational from state, scoreboard and inputs) so stalls act the same cycle:
  - RUN + load-use (no branch): PC_STALL = FETCH_STALL = DEC_BUBBLE = 1; OVERRIDE_A/B = 0.
  - RUN + BRANCH_TAKEN: FLUSH_FETCH = DEC_BUBBLE = 1; PC is not stalled (the branch target loads); overrides = 0.
  - LOAD_STALL: exactly one cycle, returns to RUN. Stall outputs = 0. The load is now in MEM, so select 2 applies normally. A BRANCH_TAKEN arriving here is handled as in RUN (go to FLUSH).
  - FLUSH: FLUSH_FETCH = DEC_BUBBLE = 1, overrides = 0. FCNT decrements each cycle; at FCNT = 0 go to RUN. BRANCH_TAKEN inside FLUSH is ignored (the instruction in EX is already a bubble).
- Counters:
  - STALL_CNT increments on each cycle with PC_STALL = 1.
  - FLUSH_CNT increments on each cycle with FLUSH_FETCH = 1.
  - Both saturate at all-ones; no wrap.
- Reset (any state, including mid-flush or mid-stall):
  - Next state RUN, scoreboard entries invalid, FCNT = 0, counters = 0.
  - While REG_RESET = 1, all outputs are forced to 0.
- rd = x0 never matches, so loads into x0 cause no stall.
- RS1 and RS2 both hazarding on the same load cause one stall cycle, not two.

Test Plan:
- Forward EX: ADD x5 then ADD x6,x5,x5 (uses both) -> second in decode: OVERRIDE_A = 1, OVERRIDE_B = 1, no stall.
- Forward MEM and priority:
  - ADD x5; NOP; SUB x7,x5,x1 -> OVERRIDE_A = 2, OVERRIDE_B = 0.
  - ADD x5; ADD x5; use x5 -> OVERRIDE_A = 1 (EX wins).
- Load-use: LW x8; ADD x9,x8,x2 -> one cycle PC_STALL = FETCH_STALL = DEC_BUBBLE = 1; next cycle OVERRIDE_A = 2; STALL_CNT = 1.
- x0 and unused sources:
  - LW x0; ADD x1,x0,x0 -> no stall, overrides 0.
  - ADDI using rs2 field equal to the previous rd with ID_USES_RS2 = 0 -> OVERRIDE_B = 0.
- Branch flush: FLUSH_CYCLES = 2, BRANCH_TAKEN pulse coincident with a load-use -> FLUSH_FETCH = DEC_BUBBLE = 1 for exactly 2 cycles, PC_STALL = 0, FLUSH_CNT = 2, STALL_CNT unchanged.
- Reset mid-flush: assert REG_RESET in the second flush cycle -> outputs 0 that cycle; afterwards state RUN, no forwarding from stale entries, counters 0.
